// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared types, widths and pair-field helpers for the correlation pair sequencer
package corr_pkg;

  localparam int STIM_W     = 4;
  localparam int PAIR_W     = 8;
  localparam int REC_PAIR_W = PAIR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_EVAL,
    ST_REPORT
  } state_t;

  function automatic logic [STIM_W-1:0] pair_i(input logic [PAIR_W-1:0] p);
    return p[PAIR_W-1:STIM_W];
  endfunction

  function automatic logic [STIM_W-1:0] pair_j(input logic [PAIR_W-1:0] p);
    return p[STIM_W-1:0];
  endfunction

endpackage

// File: rtl/corr_toggle_counter.sv
// rtl/corr_toggle_counter.sv - registers the gadget output and counts its transitions, saturating
module corr_toggle_counter
  import corr_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  input  logic             load,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic y_q;
  logic y_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= 1'b0;
      y_prev <= 1'b0;
      count  <= '0;
    end else begin
      y_q <= y_in;
      // load captures the settled baseline; enable then tracks sample-to-sample
      if (load || enable) begin
        y_prev <= y_q;
      end
      if (clear) begin
        count <= '0;
      end else if (enable && (y_q != y_prev) && (count != CNT_MAX)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/corr_pair_sequencer.sv
// rtl/corr_pair_sequencer.sv - sweeps all (i, j) stimulus pairs and reports output toggle counts
module corr_pair_sequencer
  import corr_pkg::*;
#(
  parameter int SETTLE = 8,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [STIM_W-1:0]     stim,
  input  logic                  y_in,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [REC_PAIR_W-1:0] rec_pair,
  output logic [CNT_W-1:0]      rec_toggles
);

  localparam int              PH_W    = $clog2(SETTLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SETTLE - 1);

  state_t            state;
  state_t            state_nx;
  logic [PH_W-1:0]   phase;
  logic [PAIR_W-1:0] pair;
  logic [PAIR_W-1:0] pair_nx;
  logic              phase_last;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_clear;
  logic              accept;

  assign phase_last = (phase == PH_LAST);
  assign pair_nx    = pair + 1'b1;

  // The counter register doubles as the record's toggle field; it is frozen during REPORT.
  corr_toggle_counter #(
    .CNT_W(CNT_W)
  ) u_toggle_counter (
    .clk   (clk),
    .rst   (rst),
    .y_in  (y_in),
    .load  (cnt_load),
    .enable(cnt_en),
    .clear (cnt_clear),
    .count (rec_toggles)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_clear = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_INIT;
        end
      end
      ST_INIT: begin
        if (phase_last) begin
          cnt_load = 1'b1;
          state_nx = ST_EVAL;
        end
      end
      ST_EVAL: begin
        cnt_en = 1'b1;
        if (phase_last) begin
          state_nx = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (rec_ready) begin
          accept    = 1'b1;
          cnt_clear = 1'b1;
          state_nx  = (pair == '1) ? ST_IDLE : ST_INIT;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      pair      <= '0;
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rec_valid <= 1'b0;
      rec_pair  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pair  <= '0;
            phase <= '0;
            stim  <= '0;
            busy  <= 1'b1;
          end
        end
        ST_INIT: begin
          phase <= phase_last ? '0 : phase + 1'b1;
          if (phase_last) begin
            stim <= pair_j(pair);
          end
        end
        ST_EVAL: begin
          phase <= phase_last ? '0 : phase + 1'b1;
          if (phase_last) begin
            rec_valid <= 1'b1;
            rec_pair  <= pair;
          end
        end
        ST_REPORT: begin
          if (accept) begin
            rec_valid <= 1'b0;
            pair      <= pair_nx;
            // 0xFF wrapping to 0x00 ends the sweep
            if (pair == '1) begin
              busy <= 1'b0;
              done <= 1'b1;
              stim <= '0;
            end else begin
              stim <= pair_i(pair_nx);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/corr_pair_sequencer.md
# corr_pair_sequencer

Synchronous stimulus-and-capture stage for correlation characterisation of the masked two-gate gadget (`a`, `b`, `r1`, `r2` → `y`). It sweeps every ordered pair (i, j) of 4-bit input vectors, i outer and j inner, each running 0..15. For each pair it:

- applies i and lets the gadget settle;
- applies j and counts transitions of the gadget output `y` during an evaluation window;
- emits one record per pair over a valid/ready port to the downstream logger.

It sits directly upstream of the gadget (drives its inputs) and directly downstream of it (consumes `y`).

## Interface
- `SETTLE`, default 8: cycles per phase (INIT and EVAL). Legal range ≥ 2.
- `CNT_W`, default 4: width of the toggle count.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin a sweep. Sampled only in IDLE.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when the last record is accepted.
- `stim` out 4: drives {a, b, r1, r2} of the gadget, MSB = a.
- `y_in` in 1: gadget output.
- `rec_valid` out 1: record available.
- `rec_ready` in 1: logger accepts the record.
- `rec_pair` out 8: {i, j}.
- `rec_toggles` out CNT_W: saturating count of `y` transitions in the EVAL window.

## Operation
- States: IDLE, INIT, EVAL, REPORT.
- **Reset** (synchronous, highest priority; also mid-sweep): state IDLE, pair index 0, phase counter 0, toggle counter 0, `stim`=0, `busy`=0, `done`=0, `rec_valid`=0, `rec_pair`=0, `rec_toggles`=0.
- **IDLE**
  - `start`=1 → INIT with pair index 0.
  - `busy` goes high on the same edge.
- **INIT**
  - `stim`=i for `SETTLE` cycles.
  - `y_in` is registered every cycle into `y_q`.
  - On the last INIT cycle, `y_q` becomes the baseline `y_prev`.
  - Then → EVAL.
- **EVAL**
  - `stim`=j for `SETTLE` cycles.
  - Each cycle: if `y_q` ≠ `y_prev`, increment the toggle counter; then `y_prev` ← `y_q`.
  - The counter saturates at 2^CNT_W−1; it never wraps.
  - After `SETTLE` cycles → REPORT.
- **REPORT**
  - `rec_valid`=1, `rec_pair`={i, j}, `rec_toggles` = final count.
  - All three are held stable, and `stim` holds j, until `rec_ready`=1.
  - On acceptance: toggle counter cleared, pair index incremented.
  - Index wraps 0xFF→0x00: → IDLE, `done` pulses, `busy`=0.
  - Otherwise → INIT for the next pair.
- `start` while busy is ignored.
- `rec_ready` outside REPORT has no effect.

## Timing
- `start` high at edge t → INIT from t+1, `stim`=0x0 at t+1.
- Each pair takes 2·SETTLE + 1 + (stall cycles) cycles.
- With `rec_ready` tied high and `SETTLE`=8:
  - 17 cycles per pair;
  - 4352 cycles per sweep;
  - `done` asserted in cycle t+4352.
- `y_in` → `y_q`: 1-cycle latency. An output change caused by j is therefore counted from EVAL cycle 2 onward.
- `rec_valid` rises the cycle after the last EVAL cycle.
- `rec_valid` falls the cycle after acceptance; it is never high two consecutive cycles for the same pair once accepted.
- `done` and the final `rec_valid` deassertion occur on the same edge.

## Structure
- Package `corr_pkg`:
  - state enum;
  - `STIM_W`=4;
  - `PAIR_W`=8;
  - record field widths.
- Sub-module `corr_toggle_counter`, instantiated once:
  - `y_in` register and baseline `y_prev`;
  - edge compare;
  - saturating counter;
  - `clear`/`enable` inputs driven by the FSM.
- Top holds the FSM, phase counter, pair index and output registers.

## Test plan
- **Constant output:** `y_in` tied 0, `rec_ready`=1, `SETTLE`=8 → 256 records with pairs 0x00..0xFF in order, all `rec_toggles`=0; `done` one pulse 4352 cycles after `start`.
- **XOR model:** `y_in` = a XOR b of `stim` (combinational) → pair 0x08 gives 1, 0x0C gives 0, 0xC4 gives 1, 0x33 gives 0.
- **Backpressure:** `rec_ready` low for 20 cycles during REPORT of pair 0x05 → `rec_valid`, `rec_pair`=0x05, `rec_toggles` and `stim`=0x5 all stable; no pair skipped or duplicated afterwards.
- **Saturation:** `CNT_W`=2, `SETTLE`=8, `y_in` toggling every cycle → every record reports `rec_toggles`=3.
- **Reset mid-sweep:** `rst` during EVAL of pair 0x37 → next cycle IDLE, `stim`=0, `busy`=0, `rec_valid`=0; a new `start` restarts at pair 0x00.
- **Start while busy:** `start` pulsed while busy → no effect on sequence or timing.
